// File: rtl/signal_compressor.sv
// signal_compressor
// Receive-side inverse of a pulse expander. Each high pulse on sig_in is
// measured, the extend_len cycles appended by the transmitter are removed, and
// a pulse of the original width is re-emitted on sig_out. Overlong pulses
// saturate the counter (ovf_err). Pulses no longer than the extension are
// flagged (short_err). Rising edges that arrive while a pulse is still being
// emitted are dropped (drop_err).
// PULSE_CNT_WIDTH must be strictly greater than MAX_EXTEND_LEN_WIDTH so the
// latched extension can be zero-extended into counter width.
module signal_compressor #(
  parameter int MAX_EXTEND_LEN_WIDTH = 5,
  parameter int PULSE_CNT_WIDTH      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [MAX_EXTEND_LEN_WIDTH-1:0] extend_len,
  input  logic                            sig_in,
  output logic                            sig_out,
  output logic                            busy,
  output logic                            short_err,
  output logic                            ovf_err,
  output logic                            drop_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_EMIT    = 2'd2;

  localparam logic [PULSE_CNT_WIDTH-1:0] CNT_MAX  = {PULSE_CNT_WIDTH{1'b1}};
  localparam logic [PULSE_CNT_WIDTH-1:0] CNT_ZERO = {PULSE_CNT_WIDTH{1'b0}};
  localparam logic [PULSE_CNT_WIDTH-1:0] CNT_ONE  = {{(PULSE_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                       state_r,     state_nxt_s;
  logic                             prev_sig_r;
  logic [PULSE_CNT_WIDTH-1:0]       cnt_r,       cnt_nxt_s;
  logic [PULSE_CNT_WIDTH-1:0]       out_cnt_r,   out_cnt_nxt_s;
  logic [MAX_EXTEND_LEN_WIDTH-1:0]  ext_lat_r,   ext_lat_nxt_s;
  logic                             ovf_flag_r,  ovf_flag_nxt_s;
  logic                             sig_out_r,   sig_out_nxt_s;
  logic                             busy_r,      busy_nxt_s;
  logic                             short_err_r, short_err_nxt_s;
  logic                             ovf_err_r,   ovf_err_nxt_s;
  logic                             drop_err_r,  drop_err_nxt_s;
  logic                             rise_s;
  logic [PULSE_CNT_WIDTH-1:0]       ext_wide_s;

  assign rise_s     = sig_in & ~prev_sig_r;
  assign ext_wide_s = {{(PULSE_CNT_WIDTH-MAX_EXTEND_LEN_WIDTH){1'b0}}, ext_lat_r};

  // Next-state and next-output computation for the IDLE/MEASURE/EMIT FSM.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    out_cnt_nxt_s   = out_cnt_r;
    ext_lat_nxt_s   = ext_lat_r;
    ovf_flag_nxt_s  = ovf_flag_r;
    sig_out_nxt_s   = sig_out_r;
    short_err_nxt_s = 1'b0;
    ovf_err_nxt_s   = 1'b0;
    drop_err_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Only a true rising edge starts a measurement; a level already high is ignored.
        if (rise_s) begin
          state_nxt_s    = ST_MEASURE;
          cnt_nxt_s      = CNT_ONE;
          ext_lat_nxt_s  = extend_len;
          ovf_flag_nxt_s = 1'b0;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (sig_in) begin
          if (cnt_r == CNT_MAX) begin
            ovf_flag_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          ovf_err_nxt_s = ovf_flag_r;
          // The compare guards the subtraction, so it can never underflow.
          if (cnt_r > ext_wide_s) begin
            out_cnt_nxt_s = cnt_r - ext_wide_s;
            sig_out_nxt_s = 1'b1;
            state_nxt_s   = ST_EMIT;
          end else begin
            short_err_nxt_s = 1'b1;
            state_nxt_s     = ST_IDLE;
          end
        end
      end
      ST_EMIT: begin
        drop_err_nxt_s = rise_s;
        if (out_cnt_r <= CNT_ONE) begin
          sig_out_nxt_s = 1'b0;
          out_cnt_nxt_s = CNT_ZERO;
          state_nxt_s   = ST_IDLE;
        end else begin
          out_cnt_nxt_s = out_cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        sig_out_nxt_s = 1'b0;
      end
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State, counters and registered outputs; async reset aborts any pulse at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      prev_sig_r  <= 1'b0;
      cnt_r       <= CNT_ZERO;
      out_cnt_r   <= CNT_ZERO;
      ext_lat_r   <= {MAX_EXTEND_LEN_WIDTH{1'b0}};
      ovf_flag_r  <= 1'b0;
      sig_out_r   <= 1'b0;
      busy_r      <= 1'b0;
      short_err_r <= 1'b0;
      ovf_err_r   <= 1'b0;
      drop_err_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      prev_sig_r  <= sig_in;
      cnt_r       <= cnt_nxt_s;
      out_cnt_r   <= out_cnt_nxt_s;
      ext_lat_r   <= ext_lat_nxt_s;
      ovf_flag_r  <= ovf_flag_nxt_s;
      sig_out_r   <= sig_out_nxt_s;
      busy_r      <= busy_nxt_s;
      short_err_r <= short_err_nxt_s;
      ovf_err_r   <= ovf_err_nxt_s;
      drop_err_r  <= drop_err_nxt_s;
    end
  end

  assign sig_out   = sig_out_r;
  assign busy      = busy_r;
  assign short_err = short_err_r;
  assign ovf_err   = ovf_err_r;
  assign drop_err  = drop_err_r;

endmodule

// File: tb/tb_signal_compressor.sv
// Directed bench for signal_compressor. Expected output events (recovered pulse
// widths and error pulses) are queued as stimulus is applied; a negedge monitor
// pops and compares them as the DUT produces them. A second instance with a
// 6-bit counter covers counter saturation.
module tb_signal_compressor;

  localparam int K_SHORT = 1;
  localparam int K_OVF   = 2;
  localparam int K_DROP  = 3;
  localparam int K_PULSE = 4;

  typedef struct {
    int kind;
    int val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] extend_len;
  logic       sig_in;
  logic       sig_out, busy, short_err, ovf_err, drop_err;
  logic       sig_in6;
  logic       sig_out6, busy6, short6, ovf6, drop6;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  signal_compressor #(.MAX_EXTEND_LEN_WIDTH(5), .PULSE_CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .extend_len(extend_len), .sig_in(sig_in),
    .sig_out(sig_out), .busy(busy), .short_err(short_err),
    .ovf_err(ovf_err), .drop_err(drop_err)
  );

  signal_compressor #(.MAX_EXTEND_LEN_WIDTH(5), .PULSE_CNT_WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .extend_len(extend_len), .sig_in(sig_in6),
    .sig_out(sig_out6), .busy(busy6), .short_err(short6),
    .ovf_err(ovf6), .drop_err(drop6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive an input pulse of len cycles (as sampled by the DUT).
  task automatic pulse(input int len);
    sig_in = 1'b1;
    repeat (len) tick();
    sig_in = 1'b0;
  endtask

  function automatic void expect_evt(input int k, input int v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  task automatic sb_event(input int k, input int v);
    exp_t e;
    vectors++;
    assert (exp_q.size() > 0) else begin
      miscompares++;
      $error("FAIL sb_unexpected observed=kind%0d/%0d expected=none", k, v);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_kind", k, e.kind);
      check("sb_value", v, e.val);
    end
  endtask

  // Output monitor: measures sig_out pulse widths and error pulses of the main DUT.
  int   run = 0;
  logic prev_short = 1'b0, prev_ovf = 1'b0, prev_drop = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
      prev_short = 1'b0;
      prev_ovf   = 1'b0;
      prev_drop  = 1'b0;
    end else begin
      if (short_err) begin
        sb_event(K_SHORT, 0);
        check("short_one_cycle", int'(prev_short), 0);
      end
      if (ovf_err) begin
        sb_event(K_OVF, 0);
        check("ovf_one_cycle", int'(prev_ovf), 0);
      end
      if (drop_err) begin
        sb_event(K_DROP, 0);
        check("drop_one_cycle", int'(prev_drop), 0);
      end
      if (sig_out) begin
        run++;
      end else if (run > 0) begin
        sb_event(K_PULSE, run);
        run = 0;
      end
      prev_short = short_err;
      prev_ovf   = ovf_err;
      prev_drop  = drop_err;
    end
  end

  initial begin
    int n_hi, n_ovf, n_oth, n_bad;
    rst_n      = 1'b0;
    sig_in     = 1'b0;
    sig_in6    = 1'b0;
    extend_len = 5'd0;

    // 1: outputs quiet throughout reset
    repeat (5) begin
      tick();
      check("reset_outputs", int'({sig_out, busy, short_err, ovf_err, drop_err,
                                   sig_out6, busy6, short6, ovf6, drop6}), 0);
    end
    rst_n = 1'b1;
    repeat (2) tick();

    // 2: 30-cycle pulse, extension 10 -> 20-cycle output, latency and busy window
    extend_len = 5'd10;
    expect_evt(K_PULSE, 20);
    sig_in = 1'b1;
    tick();
    check("busy_after_rise", int'(busy), 1);
    check("sigout_during_measure", int'(sig_out), 0);
    repeat (29) tick();
    sig_in = 1'b0;
    check("sigout_before_low_sample", int'(sig_out), 0);
    tick();
    check("sigout_rise_on_low_sample", int'(sig_out), 1);
    check("busy_in_emit", int'(busy), 1);
    repeat (19) tick();
    check("sigout_last_cycle", int'(sig_out), 1);
    tick();
    check("sigout_fall", int'(sig_out), 0);
    check("busy_fall", int'(busy), 0);
    repeat (3) tick();

    // 3: pulse equal to extension is short; zero extension passes width through
    extend_len = 5'd10;
    expect_evt(K_SHORT, 0);
    pulse(10);
    tick();
    check("short_err_pulse", int'(short_err), 1);
    check("short_no_sigout", int'(sig_out), 0);
    repeat (3) tick();
    extend_len = 5'd0;
    expect_evt(K_PULSE, 1);
    pulse(1);
    repeat (4) tick();
    extend_len = 5'd10;
    expect_evt(K_PULSE, 1);
    pulse(11);
    repeat (4) tick();

    // extension is latched at the rising edge; later changes ignored
    extend_len = 5'd10;
    expect_evt(K_PULSE, 10);
    sig_in = 1'b1;
    tick();
    extend_len = 5'd3;
    repeat (19) tick();
    sig_in = 1'b0;
    repeat (14) tick();

    // 4: 6-bit counter saturates at 63 -> ovf_err once, 53-cycle output
    extend_len = 5'd10;
    sig_in6 = 1'b1;
    repeat (100) tick();
    sig_in6 = 1'b0;
    n_hi = 0; n_ovf = 0; n_oth = 0;
    repeat (70) begin
      tick();
      if (sig_out6) n_hi++;
      if (ovf6) n_ovf++;
      if (short6 || drop6) n_oth++;
    end
    check("ovf_width", n_hi, 53);
    check("ovf_err_count", n_ovf, 1);
    check("ovf_other_errs", n_oth, 0);
    check("ovf_busy_end", int'(busy6), 0);

    // 5: rising edge 5 cycles into EMIT is dropped; level held past EMIT not measured
    extend_len = 5'd10;
    expect_evt(K_DROP, 0);
    expect_evt(K_PULSE, 20);
    pulse(30);
    repeat (5) tick();
    sig_in = 1'b1;
    tick();
    check("drop_err_pulse", int'(drop_err), 1);
    repeat (24) tick();
    sig_in = 1'b0;
    repeat (5) tick();
    check("no_second_measure", int'(busy), 0);

    // 6: expander-shaped 20+10 pulse, then reset mid-EMIT, then clean recovery
    extend_len = 5'd10;
    expect_evt(K_PULSE, 20);
    pulse(30);
    repeat (25) tick();
    pulse(30);
    tick();
    check("emit_before_reset", int'(sig_out), 1);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("reset_kills_sigout", int'(sig_out), 0);
    check("reset_kills_busy", int'(busy), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    n_bad = 0;
    repeat (30) begin
      tick();
      if (sig_out || busy) n_bad++;
    end
    check("no_partial_after_reset", n_bad, 0);
    expect_evt(K_PULSE, 20);
    pulse(30);
    repeat (25) tick();

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
